// File: rtl/ad9866_pkg.sv
// Shared definitions for the AD9866 SPI configuration master: init table,
// frame field positions and controller state encoding.
package ad9866_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned RD_BIT   = 15;
  localparam int unsigned ADDR_MSB = 12;
  localparam int unsigned ADDR_LSB = 8;

  // Entry index is the register address; bit 8 enables the write, [7:0] is the data.
  localparam bit [0:31][8:0] AD9866_INIT = {
    9'h180, 9'h000, 9'h000, 9'h000, 9'h136, 9'h000, 9'h154, 9'h101,
    9'h120, 9'h100, 9'h10F, 9'h1C0, 9'h143, 9'h101, 9'h000, 9'h000,
    9'h000, 9'h100, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
  };

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } spi_state_e;

  function automatic logic [FRAME_W-1:0] init_frame(input logic [4:0] idx,
                                                    input logic [7:0] data);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[ADDR_MSB:ADDR_LSB] = idx;
    f[7:0] = data;
    return f;
  endfunction

endpackage

// File: rtl/ad9866_spi_master_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting channel at or after ptr,
// returning both a one-hot grant and its index.
module rr_arbiter #(
  parameter  int unsigned NREQ  = 3,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [NREQ-1:0] rot;
  logic [IDX_W:0]  off;
  logic [IDX_W:0]  sum;
  logic            found;

  always_comb begin
    // Rotate so that bit 0 is the channel at ptr, then take the lowest set bit.
    rot   = NREQ'({req, req} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = (IDX_W+1)'(i);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
    grant_valid = found;
    grant_idx   = sum[IDX_W-1:0];
    grant       = found ? (NREQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/ad9866_spi_master.sv
// AD9866 SPI configuration master: plays the init table after reset or reinit,
// then serves round-robin write/read request channels on a 16-bit SPI frame.
module ad9866_spi_master
  import ad9866_pkg::*;
#(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned INIT_LEN   = 20,
  parameter int unsigned SCLK_DIV   = 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              sclk,
  output logic              sen_n,
  output logic              sdio,
  input  logic              sdo,
  input  logic              reinit,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [16*NREQ-1:0] req_frame,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              init_done,
  output logic              busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DIV_W = $clog2(SCLK_DIV + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  spi_state_e         state_q, state_d;
  logic [5:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               sclk_q, sclk_d;
  logic               sen_n_q, sen_n_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [NREQ-1:0]    req_ack_q, req_ack_d;
  logic               init_done_q, init_done_d;
  logic               reinit_pend_q, reinit_pend_d;

  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [FRAME_W-1:0] sel_frame;
  logic [8:0]         entry;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_frame = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_frame = req_frame[16*i +: 16];
    end
  end

  assign entry = AD9866_INIT[ptr_q[4:0]];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rr_ptr_d      = rr_ptr_q;
    frame_d       = frame_q;
    shift_d       = shift_q;
    sclk_d        = sclk_q;
    sen_n_d       = sen_n_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    req_ack_d     = '0;
    init_done_d   = init_done_q;
    reinit_pend_d = reinit_pend_q | reinit;

    unique case (state_q)
      ST_INIT: begin
        if (ptr_q == 6'(INIT_LEN)) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 6'd1;
          if (entry[8]) begin
            frame_d = init_frame(ptr_q[4:0], entry[7:0]);
            state_d = ST_LOAD;
          end
        end
      end
      ST_IDLE: begin
        if (reinit_pend_q) begin
          reinit_pend_d = reinit;
          init_done_d   = 1'b0;
          ptr_d         = '0;
          state_d       = ST_INIT;
        end else if (init_done_q && grant_valid) begin
          req_ack_d = grant;
          frame_d   = sel_frame;
          rr_ptr_d  = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_d   = frame_q;
        sen_n_d   = 1'b0;
        sclk_d    = 1'b0;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_cnt_q == DIV_W'(SCLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of a high phase: sample sdo and present the next bit.
            sclk_d    = 1'b0;
            shift_d   = {shift_q[14:0], sdo};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              sen_n_d   = 1'b1;
              gap_cnt_d = '0;
              state_d   = ST_GAP;
              if (frame_q[RD_BIT]) begin
                rd_data_d  = {shift_q[6:0], sdo};
                rd_valid_d = 1'b1;
              end
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          if (reinit_pend_q) begin
            reinit_pend_d = reinit;
            init_done_d   = 1'b0;
            ptr_d         = '0;
            state_d       = ST_INIT;
          end else if (!init_done_q) begin
            state_d = ST_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      ptr_q         <= '0;
      rr_ptr_q      <= '0;
      frame_q       <= '0;
      shift_q       <= '0;
      sclk_q        <= 1'b0;
      sen_n_q       <= 1'b1;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      req_ack_q     <= '0;
      init_done_q   <= 1'b0;
      reinit_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      rr_ptr_q      <= rr_ptr_d;
      frame_q       <= frame_d;
      shift_q       <= shift_d;
      sclk_q        <= sclk_d;
      sen_n_q       <= sen_n_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      req_ack_q     <= req_ack_d;
      init_done_q   <= init_done_d;
      reinit_pend_q <= reinit_pend_d;
    end
  end

  assign sclk      = sclk_q;
  assign sen_n     = sen_n_q;
  assign sdio      = shift_q[15] & ~sen_n_q;
  assign req_ack   = req_ack_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign init_done = init_done_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_GAP);

endmodule
